// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel-rate divider, x/y raster counters, registered
// sync/active/strobe outputs and a one-shot scan-position capture.
//
// state | meaning
// IDLE  | no capture outstanding; a capture_req arms the capture
// PEND  | capture armed; latch x/y at the next strobe inside the visible area
module vga_scan_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture_req,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] capture_x,
    output logic [9:0] capture_y,
    output logic       capture_valid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cap_state_t;

    cap_state_t       cap_state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             pix_nxt;

    // Next raster position; every decoded output is derived from these so the
    // registered flags always describe the x,y registered alongside them.
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        pix_nxt = (div_nxt == DIV_LAST);
        x_nxt   = x;
        y_nxt   = y;
        if (pix_en) begin
            if (x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y == Y_LAST) ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
    end

    // Divider, raster counters and decoded timing outputs, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            pix_en      <= pix_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vsync       <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            active      <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            line_start  <= pix_nxt && (x_nxt == '0);
            frame_start <= pix_nxt && (x_nxt == '0) && (y_nxt == '0);
        end
    end

    // Capture FSM: a request only arms; the latch happens at a later visible
    // strobe, and requests arriving while armed are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state     <= IDLE;
            capture_x     <= '0;
            capture_y     <= '0;
            capture_valid <= 1'b0;
        end else begin
            capture_valid <= 1'b0;
            unique case (cap_state)
                IDLE: begin
                    if (capture_req) begin
                        cap_state <= PEND;
                    end
                end
                PEND: begin
                    if (pix_en && active) begin
                        capture_x     <= x;
                        capture_y     <= y;
                        capture_valid <= 1'b1;
                        cap_state     <= IDLE;
                    end
                end
                default: cap_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a shrunken raster so whole frames fit in a short
// run. Expected outputs come from the elapsed clock count since reset release.
module tb_vga_scan_gen;

    localparam int D  = 4;
    localparam int HA = 20;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VA = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       capture_req = 1'b0;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic [9:0] capture_x;
    logic [9:0] capture_y;
    logic       capture_valid;

    int n_tests = 0;
    int n_fail  = 0;

    longint n;          // posedges since reset release
    bit     pend;
    int     cx;
    int     cy;
    bit     cv;
    longint last_fs;
    int     fs_seen;

    vga_scan_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .capture_req(capture_req),
        .pix_en(pix_en), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
        .active(active), .line_start(line_start), .frame_start(frame_start),
        .capture_x(capture_x), .capture_y(capture_y), .capture_valid(capture_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Raster position after nn clock edges: pixel k = nn / D, row-major scan.
    function automatic void ref_pos(input longint nn, output int mx, output int my, output bit pe);
        longint k;
        k  = nn / D;
        mx = int'(k % HT);
        my = int'((k / HT) % VT);
        pe = (nn % D) == (D - 1);
    endfunction

    function automatic bit ref_active(input int mx, input int my);
        return (mx < HA) && (my < VA);
    endfunction

    task automatic check_all();
        int mx, my;
        bit pe;
        ref_pos(n, mx, my, pe);
        check("pix_en", 32'(pix_en), 32'(pe));
        check("x", 32'(x), 32'(mx));
        check("y", 32'(y), 32'(my));
        check("hsync", 32'(hsync), 32'(!(mx >= HA + HF && mx < HA + HF + HS)));
        check("vsync", 32'(vsync), 32'(!(my >= VA + VF && my < VA + VF + VS)));
        check("active", 32'(active), 32'(ref_active(mx, my)));
        check("line_start", 32'(line_start), 32'(pe && mx == 0));
        check("frame_start", 32'(frame_start), 32'(pe && mx == 0 && my == 0));
        check("capture_valid", 32'(capture_valid), 32'(cv));
        check("capture_x", 32'(capture_x), 32'(cx));
        check("capture_y", 32'(capture_y), 32'(cy));
        if (frame_start === 1'b1) begin
            if (fs_seen > 0) check("frame_period", 32'(n - last_fs), 32'(FRAME_CLKS));
            fs_seen++;
            last_fs = n;
        end
    endtask

    // One clock with capture_req held at req; the capture model decides from
    // the pre-edge position whether this edge latches.
    task automatic step(input bit req);
        int mx, my;
        bit pe;
        bit pend_old;
        capture_req = req;
        ref_pos(n, mx, my, pe);
        pend_old = pend;
        @(posedge clk);
        n++;
        if (pend_old && pe && ref_active(mx, my)) begin
            cx   = mx;
            cy   = my;
            cv   = 1'b1;
            pend = 1'b0;
        end else begin
            cv = 1'b0;
        end
        if (!pend_old && req) pend = 1'b1;
        #1;
        capture_req = 1'b0;
        check_all();
    endtask

    // Step until the current cycle is the strobe of pixel (wx, wy).
    task automatic wait_pixel(input int wx, input int wy);
        int mx, my;
        bit pe;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            ref_pos(n, mx, my, pe);
            if (pe && mx == wx && my == wy) return;
            step(1'b0);
        end
        check("wait_pixel_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_capture(input string tag, input int ex, input int ey);
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            step(1'b0);
            if (capture_valid === 1'b1) begin
                check({tag, "_x"}, 32'(capture_x), 32'(ex));
                check({tag, "_y"}, 32'(capture_y), 32'(ey));
                return;
            end
        end
        check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        n       = 0;
        pend    = 1'b0;
        cx      = 0;
        cy      = 0;
        cv      = 1'b0;
        fs_seen = 0;
        last_fs = 0;
        check_all();
    endtask

    initial begin
        int strobes;
        n = 0; pend = 0; cx = 0; cy = 0; cv = 0; fs_seen = 0; last_fs = 0;
        repeat (3) @(posedge clk);
        release_reset();

        // One full frame plus a bit: count strobes between frame starts.
        strobes = 0;
        for (int i = 0; i < FRAME_CLKS + 8; i++) begin
            step(1'b0);
            if (pix_en === 1'b1 && i < FRAME_CLKS) strobes++;
        end
        check("strobes_per_frame", 32'(strobes), 32'(HT * VT));

        // Request on a visible strobe only arms; latch lands on the next pixel.
        wait_pixel(5, 3);
        step(1'b1);
        wait_capture("cap_mid", 6, 3);

        // Request in the last visible row past the visible columns waits
        // through blanking and the frame wrap; a second request is dropped.
        wait_pixel(HA + 10, VA - 1);
        step(1'b1);
        repeat (9) step(1'b0);
        step(1'b1);
        wait_capture("cap_wrap", 0, 0);
        repeat (HT * D) step(1'b0);

        // Randomized requests against the model.
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            step($urandom_range(0, 29) == 0);
        end

        // Reset mid-line while a capture is pending.
        wait_pixel(8, 2);
        step(1'b1);
        step(1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_pix_en", 32'(pix_en), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_active", 32'(active), 32'd1);
        check("rst_line_start", 32'(line_start), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_capture_x", 32'(capture_x), 32'd0);
        check("rst_capture_y", 32'(capture_y), 32'd0);
        check("rst_capture_valid", 32'(capture_valid), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < FRAME_CLKS + 16; i++) begin
            step(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
